// File: rtl/gerador_estado_freq.sv
// State/phase generator for the 7-segment animation: a prescaler drives FREQ/TICK,
// and a 4-state FSM moves ST on debounced button edges, returning to idle on timeout.
module gerador_estado_freq #(
   parameter int DIV            = 12500000,
   parameter int TIMEOUT_VOLTAS = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       AVANCA,
   input  logic       CANCELA,
   output logic [1:0] ST,
   output logic [1:0] FREQ,
   output logic       TICK
);

   localparam int            CW          = $clog2(DIV);
   localparam logic [CW-1:0] CNT_LAST    = CW'(DIV - 1);
   localparam int            VW          = (TIMEOUT_VOLTAS > 1) ? $clog2(TIMEOUT_VOLTAS) : 1;
   localparam logic [VW-1:0] VOLTAS_LAST = VW'((TIMEOUT_VOLTAS > 0) ? (TIMEOUT_VOLTAS - 1) : 0);
   localparam bit            TO_EN       = (TIMEOUT_VOLTAS != 0);

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_UM   = 2'b01,
      S_DOIS = 2'b10,
      S_TRES = 2'b11
   } estado_t;

   estado_t         r_estado;
   estado_t         w_prox;
   logic            r_a_q;
   logic            r_c_q;
   logic [CW-1:0]   r_cnt;
   logic [1:0]      r_freq;
   logic            r_tick;
   logic [VW-1:0]   r_voltas;
   logic            w_rise_a;
   logic            w_rise_c;
   logic            w_tick_edge;
   logic            w_timeout;
   logic            w_change;

   assign w_rise_a    = AVANCA & ~r_a_q;
   assign w_rise_c    = CANCELA & ~r_c_q;
   assign w_tick_edge = (r_cnt == CNT_LAST);
   assign w_timeout   = TO_EN && (r_estado == S_TRES) && w_tick_edge &&
                        (r_freq == 2'b11) && (r_voltas == VOLTAS_LAST);

   // Next-state selection; any taken transition (even idle->idle on cancel) flags a change.
   always_comb begin
      w_prox   = r_estado;
      w_change = 1'b0;
      if (w_rise_c) begin
         w_prox   = S_IDLE;
         w_change = 1'b1;
      end else if (w_rise_a) begin
         w_change = 1'b1;
         case (r_estado)
            S_IDLE:  w_prox = S_UM;
            S_UM:    w_prox = S_DOIS;
            S_DOIS:  w_prox = S_TRES;
            S_TRES:  w_prox = S_IDLE;
            default: w_prox = S_IDLE;
         endcase
      end else if (w_timeout) begin
         w_prox   = S_IDLE;
         w_change = 1'b1;
      end else begin
         w_prox   = r_estado;
         w_change = 1'b0;
      end
   end

   // State register, edge-detect history, prescaler and timeout wrap counter.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_estado <= S_IDLE;
         r_a_q    <= 1'b1;
         r_c_q    <= 1'b1;
         r_cnt    <= '0;
         r_freq   <= 2'b00;
         r_tick   <= 1'b0;
         r_voltas <= '0;
      end else begin
         r_a_q    <= AVANCA;
         r_c_q    <= CANCELA;
         r_estado <= w_prox;
         // A state change restarts the animation and overrides a coincident tick.
         if (w_change) begin
            r_cnt    <= '0;
            r_freq   <= 2'b00;
            r_tick   <= 1'b0;
            r_voltas <= '0;
         end else if (w_tick_edge) begin
            r_cnt  <= '0;
            r_freq <= r_freq + 2'd1;
            r_tick <= 1'b1;
            if ((r_estado == S_TRES) && (r_freq == 2'b11)) begin
               r_voltas <= r_voltas + VW'(1);
            end else begin
               r_voltas <= r_voltas;
            end
         end else begin
            r_cnt  <= r_cnt + CW'(1);
            r_tick <= 1'b0;
         end
      end
   end

   assign ST   = r_estado;
   assign FREQ = r_freq;
   assign TICK = r_tick;

endmodule
